axi4_lite_slave_ctrl: RTL



---
 rtl/axi4_lite_slave_ctrl_pkg.sv | 18 +
 rtl/axi4_lite_slave_ctrl_port_arb.sv | 33 +++
 rtl/axi4_lite_slave_ctrl.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_lite_slave_ctrl_pkg.sv
// Shared types for the AXI4-Lite slave controller.
//   - AXI response codes
//   - write / read channel FSM state encodings
//   - memory-port grant owner used by the arbiter
package axi4_types;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {W_IDLE, W_MEM, W_RESP} wr_state_t;
    typedef enum logic [1:0] {R_IDLE, R_MEM, R_WAIT, R_RESP} rd_state_t;

    // Which side was served by the most recent contested grant.
    typedef enum logic {GRANT_W, GRANT_R} grant_t;

endpackage

// File: rtl/axi4_lite_slave_ctrl_port_arb.sv
// Two-requester alternating-priority arbiter for the shared memory port.
//   clk, rst_n       : clock, asynchronous active-low reset
//   req_w, req_r     : write / read side wants the port next cycle
//   grant_w, grant_r : combinational one-hot (or zero) grant
// An uncontested request wins at once; a contested one goes to the side
// that did not win the previous contest (read first after reset).
module axi4_lite_port_arb
    import axi4_types::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic req_w,
    input  logic req_r,
    output logic grant_w,
    output logic grant_r
);

    grant_t last_grant_reg;

    always_comb begin
        grant_w = req_w && (!req_r || (last_grant_reg == GRANT_R));
        grant_r = req_r && (!req_w || (last_grant_reg == GRANT_W));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_reg <= GRANT_W;
        end else if (req_w && req_r) begin
            last_grant_reg <= grant_r ? GRANT_R : GRANT_W;
        end
    end

endmodule

// File: rtl/axi4_lite_slave_ctrl.sv
// AXI4-Lite slave: terminates AW/W/B/AR/R and turns each transaction into a
// single-cycle strobe on a word-addressed memory port (1-cycle read latency).
// One write and one read may be outstanding; they share the port through
// axi4_lite_port_arb. Addresses beyond DEPTH words answer SLVERR untouched.
//   ACLK, ARSTn           : clock, asynchronous active-low reset
//   AW*/W*/B*/AR*/R*      : AXI4-Lite slave channels (PROT ignored)
//   mem_en/mem_we         : access strobe / write qualifier (registered)
//   mem_addr/wdata/wstrb  : word index, write data, byte enables (registered)
//   mem_rdata             : read data, valid the cycle after a read strobe
module axi4_lite_slave_ctrl
    import axi4_types::*;
#(
    parameter  int SIZE_WORD = 32,
    parameter  int DEPTH     = 256,
    localparam int SIZE_STRB = SIZE_WORD / 8,
    localparam int ADDR_W    = $clog2(DEPTH)
) (
    input  logic                 ACLK,
    input  logic                 ARSTn,
    input  logic                 AWVALID,
    output logic                 AWREADY,
    input  logic [SIZE_WORD-1:0] AWADDR,
    input  logic [2:0]           AWPROT,
    input  logic                 WVALID,
    output logic                 WREADY,
    input  logic [SIZE_WORD-1:0] WDATA,
    input  logic [SIZE_STRB-1:0] WSTRB,
    output logic                 BVALID,
    input  logic                 BREADY,
    output logic [1:0]           BRESP,
    input  logic                 ARVALID,
    output logic                 ARREADY,
    input  logic [SIZE_WORD-1:0] ARADDR,
    input  logic [2:0]           ARPROT,
    output logic                 RVALID,
    input  logic                 RREADY,
    output logic [SIZE_WORD-1:0] RDATA,
    output logic [1:0]           RRESP,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [SIZE_WORD-1:0] mem_wdata,
    output logic [SIZE_STRB-1:0] mem_wstrb,
    input  logic [SIZE_WORD-1:0] mem_rdata
);

    wr_state_t            wr_state_reg, wr_state_next;
    rd_state_t            rd_state_reg, rd_state_next;
    logic                 aw_held_reg, aw_held_next, w_held_reg, w_held_next;
    logic [SIZE_WORD-1:0] aw_addr_reg, aw_addr_next;
    logic [SIZE_WORD-1:0] w_data_reg, w_data_next;
    logic [SIZE_STRB-1:0] w_strb_reg, w_strb_next;
    logic [ADDR_W-1:0]    ar_idx_reg, ar_idx_next;
    // gnt_*_reg: the strobe currently on the port belongs to that side.
    logic                 gnt_w_reg, gnt_r_reg;
    logic                 bvalid_reg, bvalid_next, rvalid_reg, rvalid_next;
    logic [1:0]           bresp_reg, bresp_next, rresp_reg, rresp_next;
    logic [SIZE_WORD-1:0] rdata_reg, rdata_next;
    logic                 mem_en_reg, mem_en_next, mem_we_reg, mem_we_next;
    logic [ADDR_W-1:0]    mem_addr_reg, mem_addr_next;
    logic [SIZE_WORD-1:0] mem_wdata_reg, mem_wdata_next;
    logic [SIZE_STRB-1:0] mem_wstrb_reg, mem_wstrb_next;

    logic                 aw_hs, w_hs, aw_have, w_have;
    logic [SIZE_WORD-1:0] aw_addr_cur, w_data_cur;
    logic [SIZE_STRB-1:0] w_strb_cur;
    logic [ADDR_W-1:0]    ar_idx_cur;
    logic                 req_w, req_r, grant_w, grant_r;
    logic                 unused_bits;

    function automatic logic in_range(input logic [SIZE_WORD-1:0] addr);
        return (addr >> (ADDR_W + 2)) == '0;
    endfunction

    // READYs decode registered state only.
    assign AWREADY = !aw_held_reg;
    assign WREADY  = !w_held_reg;
    assign ARREADY = (rd_state_reg == R_IDLE);

    assign aw_hs   = AWVALID && AWREADY;
    assign w_hs    = WVALID && WREADY;
    assign aw_have = aw_held_reg || aw_hs;
    assign w_have  = w_held_reg || w_hs;

    // Bypass the holding registers in the handshake cycle so the memory
    // strobe can be registered for the very next cycle.
    assign aw_addr_cur = aw_held_reg ? aw_addr_reg : AWADDR;
    assign w_data_cur  = w_held_reg ? w_data_reg : WDATA;
    assign w_strb_cur  = w_held_reg ? w_strb_reg : WSTRB;
    assign ar_idx_cur  = (rd_state_reg == R_IDLE) ? ARADDR[ADDR_W+1:2] : ar_idx_reg;

    // A side in *_MEM without its strobe on the port lost the last contest.
    assign req_w = ((wr_state_reg == W_IDLE) && aw_have && w_have && in_range(aw_addr_cur))
                || ((wr_state_reg == W_MEM) && !gnt_w_reg);
    assign req_r = ((rd_state_reg == R_IDLE) && ARVALID && in_range(ARADDR))
                || ((rd_state_reg == R_MEM) && !gnt_r_reg);

    axi4_lite_port_arb u_arb (
        .clk     (ACLK),
        .rst_n   (ARSTn),
        .req_w   (req_w),
        .req_r   (req_r),
        .grant_w (grant_w),
        .grant_r (grant_r)
    );

    always_comb begin
        wr_state_next = wr_state_reg;
        aw_held_next  = aw_held_reg;
        w_held_next   = w_held_reg;
        aw_addr_next  = aw_addr_reg;
        w_data_next   = w_data_reg;
        w_strb_next   = w_strb_reg;
        bvalid_next   = bvalid_reg;
        bresp_next    = bresp_reg;

        if (aw_hs) begin
            aw_held_next = 1'b1;
            aw_addr_next = AWADDR;
        end
        if (w_hs) begin
            w_held_next = 1'b1;
            w_data_next = WDATA;
            w_strb_next = WSTRB;
        end

        case (wr_state_reg)
            W_IDLE: begin
                if (aw_have && w_have) begin
                    if (in_range(aw_addr_cur)) begin
                        wr_state_next = W_MEM;
                    end else begin
                        wr_state_next = W_RESP;
                        bvalid_next   = 1'b1;
                        bresp_next    = RESP_SLVERR;
                    end
                end
            end
            W_MEM: begin
                if (gnt_w_reg) begin
                    wr_state_next = W_RESP;
                    bvalid_next   = 1'b1;
                    bresp_next    = RESP_OKAY;
                end
            end
            W_RESP: begin
                if (BREADY) begin
                    wr_state_next = W_IDLE;
                    bvalid_next   = 1'b0;
                    aw_held_next  = 1'b0;
                    w_held_next   = 1'b0;
                end
            end
            default: wr_state_next = W_IDLE;
        endcase
    end

    always_comb begin
        rd_state_next = rd_state_reg;
        ar_idx_next   = ar_idx_reg;
        rvalid_next   = rvalid_reg;
        rresp_next    = rresp_reg;
        rdata_next    = rdata_reg;

        case (rd_state_reg)
            R_IDLE: begin
                if (ARVALID) begin
                    ar_idx_next = ARADDR[ADDR_W+1:2];
                    if (in_range(ARADDR)) begin
                        rd_state_next = R_MEM;
                    end else begin
                        rd_state_next = R_RESP;
                        rvalid_next   = 1'b1;
                        rresp_next    = RESP_SLVERR;
                        rdata_next    = '0;
                    end
                end
            end
            R_MEM: begin
                if (gnt_r_reg) begin
                    rd_state_next = R_WAIT;
                end
            end
            R_WAIT: begin
                rd_state_next = R_RESP;
                rvalid_next   = 1'b1;
                rresp_next    = RESP_OKAY;
                rdata_next    = mem_rdata;
            end
            R_RESP: begin
                if (RREADY) begin
                    rd_state_next = R_IDLE;
                    rvalid_next   = 1'b0;
                end
            end
            default: rd_state_next = R_IDLE;
        endcase
    end

    always_comb begin
        mem_en_next    = grant_w || grant_r;
        mem_we_next    = grant_w;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;
        mem_wstrb_next = mem_wstrb_reg;
        if (grant_w) begin
            mem_addr_next  = aw_addr_cur[ADDR_W+1:2];
            mem_wdata_next = w_data_cur;
            mem_wstrb_next = w_strb_cur;
        end else if (grant_r) begin
            mem_addr_next  = ar_idx_cur;
        end
    end

    always_ff @(posedge ACLK or negedge ARSTn) begin
        if (!ARSTn) begin
            wr_state_reg  <= W_IDLE;
            rd_state_reg  <= R_IDLE;
            aw_held_reg   <= 1'b0;
            w_held_reg    <= 1'b0;
            aw_addr_reg   <= '0;
            w_data_reg    <= '0;
            w_strb_reg    <= '0;
            ar_idx_reg    <= '0;
            gnt_w_reg     <= 1'b0;
            gnt_r_reg     <= 1'b0;
            bvalid_reg    <= 1'b0;
            bresp_reg     <= RESP_OKAY;
            rvalid_reg    <= 1'b0;
            rresp_reg     <= RESP_OKAY;
            rdata_reg     <= '0;
            mem_en_reg    <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            mem_wstrb_reg <= '0;
        end else begin
            wr_state_reg  <= wr_state_next;
            rd_state_reg  <= rd_state_next;
            aw_held_reg   <= aw_held_next;
            w_held_reg    <= w_held_next;
            aw_addr_reg   <= aw_addr_next;
            w_data_reg    <= w_data_next;
            w_strb_reg    <= w_strb_next;
            ar_idx_reg    <= ar_idx_next;
            gnt_w_reg     <= grant_w;
            gnt_r_reg     <= grant_r;
            bvalid_reg    <= bvalid_next;
            bresp_reg     <= bresp_next;
            rvalid_reg    <= rvalid_next;
            rresp_reg     <= rresp_next;
            rdata_reg     <= rdata_next;
            mem_en_reg    <= mem_en_next;
            mem_we_reg    <= mem_we_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
            mem_wstrb_reg <= mem_wstrb_next;
        end
    end

    assign BVALID    = bvalid_reg;
    assign BRESP     = bresp_reg;
    assign RVALID    = rvalid_reg;
    assign RRESP     = rresp_reg;
    assign RDATA     = rdata_reg;
    assign mem_en    = mem_en_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign mem_wstrb = mem_wstrb_reg;

    // PROT and the byte offset carry no meaning for a word-wide slave.
    assign unused_bits = ^{AWPROT, ARPROT, aw_addr_reg[1:0]};

endmodule
